bp_clint_cmd_initiator: RTL and testbench
=========================================

// Module: bp_clint_cmd_initiator
// PURPOSE
// - Master-side mem-msg initiator that drives the CLINT slice: converts simple dword register
//   requests (rd/wr, addr, data) into bp_cce_mem_msg_s uncached commands and returns read data.
// - Tracks outstanding commands in order and checks each response against the issued command.
// - Sits between a host/debug/config agent and the CLINT mem_cmd/mem_resp port.
// PARAMETERS
// - bp_params_p        e_bp_inv_cfg  processor config; supplies paddr/dword/cce_block widths
// - max_outstanding_p  2             max in-flight cmds; equals CLINT slice FIFO depth, >=1
// - timeout_cycles_p   1024          response watchdog limit (BP_CLINT_INIT_TIMEOUT_EN only)
// PORTS
// - clk_i            in   1                     clock
// - reset_i          in   1                     synchronous, active-high reset
// - req_v_i          in   1                     request valid
// - req_ready_o      out  1                     request accepted when req_v_i & req_ready_o
// - req_we_i         in   1                     1=write, 0=read
// - req_addr_i       in   paddr_width_p         target CLINT register address
// - req_data_i       in   dword_width_p         write data
// - mem_cmd_o        out  cce_mem_msg_width_lp  command message
// - mem_cmd_v_o      out  1                     command valid
// - mem_cmd_ready_i  in   1                     responder ready (valid-then-ready)
// - mem_resp_i       in   cce_mem_msg_width_lp  response message
// - mem_resp_v_i     in   1                     response valid
// - mem_resp_yumi_o  out  1                     response consumed this cycle
// - rsp_v_o          out  1                     completion valid
// - rsp_we_o         out  1                     completion was a write
// - rsp_data_o       out  dword_width_p         read data (low dword of resp data); 0 for writes
// - rsp_yumi_i       in   1                     completion consumed
// - mismatch_o       out  1                     sticky: resp msg_type/addr != head of tracker
// - timeout_o        out  1                     sticky watchdog flag
// BEHAVIOUR
// - Reset: all outputs 0; credit count 0; tracker, cmd buffer and rsp buffer empty.
// - Cmd encoding: msg_type = we ? e_cce_mem_uc_wr : e_cce_mem_uc_rd; size = e_mem_msg_size_8;
//   payload = 0; addr = req_addr_i; data = zero-extended req_data_i (0 for reads).
// - Cmd path: 1-entry output register; accept -> mem_cmd_v_o high next cycle; held stable
//   until mem_cmd_ready_i; a new request may load in the same cycle the old one drains.
// - req_ready_o = (cmd buffer empty | draining) & credits < max_outstanding_p & ~blocked.
// - Credits: +1 on accept, -1 on mem_resp_yumi_o; both in one cycle -> unchanged.
// - Tracker: in-order FIFO of {we, addr}, depth max_outstanding_p, pushed on accept,
//   popped on mem_resp_yumi_o. Response msg_type or addr differing from head -> mismatch_o=1
//   (sticky to reset); response still retired and delivered.
// - Response with tracker empty: consumed, dropped, mismatch_o=1.
// - Rsp path: 1-entry register; mem_resp_yumi_o = mem_resp_v_i & (~rsp_v_o | rsp_yumi_i).
//   Latency mem_resp_v_i -> rsp_v_o: 1 cycle. Full buffer backpressures responder.
// - Width rules: rsp_data_o = mem_resp_i.data[0+:dword_width_p]; upper block bits ignored.
// - Reset mid-operation discards all in-flight state; initiator and CLINT share reset_i.
// CONFIGURATION
// - BP_CLINT_INIT_TIMEOUT_EN defined: counter clears on mem_resp_yumi_o or credits==0,
//   else increments each cycle; reaching timeout_cycles_p sets timeout_o (sticky) and
//   blocks further requests (req_ready_o=0) until reset; outstanding responses still accepted.
// - Not defined: counter absent, timeout_o tied 0, never blocks.
// TESTING
// - Write 64'h0000_0000_0000_1000 to mtimecmp base, then read it -> uc_wr then uc_rd on
//   mem_cmd_o; read completion rsp_data_o=64'h1000, rsp_we_o=0; mismatch_o stays 0.
// - Hold mem_resp_yumi path stalled, issue 3 reqs with max_outstanding_p=2 -> 2 accepted,
//   3rd sees req_ready_o=0 until first response retired, then accepted same cycle.
// - Accept + response retire in same cycle at credits=1 -> credits stay 1, no bubble.
// - Hold rsp_yumi_i=0 with rsp_v_o=1, present second response -> mem_resp_yumi_o=0 until drain.
// - Inject response addr 0x10 when tracker head addr 0x20 -> mismatch_o=1 next cycle, sticky.
// - With macro, timeout_cycles_p=16, never respond -> timeout_o=1 after 16 cycles,
//   req_ready_o=0; reset_i pulse -> timeout_o=0, credits=0, req_ready_o=1.

Source files
------------

// File: rtl/bp_clint_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module   : bp_clint_cmd_initiator
// Purpose  : Master-side mem-msg initiator for the CLINT slice. Turns simple
//            dword register requests (rd/wr, addr, data) into uncached
//            mem-msg commands, tracks in-flight commands in order, checks each
//            response against the command it should belong to, and returns
//            read data to the requester.
// Message  : {data[cce_block_width_p], payload[8], size[3], addr[paddr_width_p],
//            msg_type[4]}, msg_type in the least significant bits.
// Ports    : clk_i, reset_i            clock, synchronous active-high reset
//            req_v_i/req_ready_o        request handshake
//            req_we_i/addr_i/data_i     request contents
//            mem_cmd_o/_v_o/_ready_i    command to the CLINT (valid-then-ready)
//            mem_resp_i/_v_i/_yumi_o    response from the CLINT
//            rsp_v_o/we_o/data_o/yumi_i completion to the requester
//            mismatch_o                 sticky: response did not match tracker
//            timeout_o                  sticky: response watchdog expired
// Config   : BP_CLINT_INIT_TIMEOUT_EN enables the response watchdog; when
//            undefined timeout_o is tied low and requests are never blocked.
// Revision : 1.0 - initial release
// ============================================================================
module bp_clint_cmd_initiator #(
  parameter int paddr_width_p     = 40,
  parameter int dword_width_p     = 64,
  parameter int cce_block_width_p = 512,
  parameter int max_outstanding_p = 2,
  parameter int timeout_cycles_p  = 1024,
  localparam int cce_mem_msg_width_lp = 4 + paddr_width_p + 3 + 8 + cce_block_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            req_v_i,
  output logic                            req_ready_o,
  input  logic                            req_we_i,
  input  logic [paddr_width_p-1:0]        req_addr_i,
  input  logic [dword_width_p-1:0]        req_data_i,
  output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o,
  output logic                            mem_cmd_v_o,
  input  logic                            mem_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i,
  input  logic                            mem_resp_v_i,
  output logic                            mem_resp_yumi_o,
  output logic                            rsp_v_o,
  output logic                            rsp_we_o,
  output logic [dword_width_p-1:0]        rsp_data_o,
  input  logic                            rsp_yumi_i,
  output logic                            mismatch_o,
  output logic                            timeout_o
);

  localparam int C_TYPE_W    = 4;
  localparam int C_SIZE_W    = 3;
  localparam int C_ADDR_LSB  = C_TYPE_W;
  localparam int C_SIZE_LSB  = C_ADDR_LSB + paddr_width_p;
  localparam int C_DATA_LSB  = C_SIZE_LSB + C_SIZE_W + 8;
  localparam int C_CNT_W     = $clog2(max_outstanding_p + 1);
  localparam int C_PTR_W     = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

  localparam logic [C_TYPE_W-1:0] C_UC_RD  = 4'b0010;
  localparam logic [C_TYPE_W-1:0] C_UC_WR  = 4'b0011;
  localparam logic [C_SIZE_W-1:0] C_SIZE_8 = 3'b011;
  localparam logic [C_CNT_W-1:0]  C_MAX    = C_CNT_W'(max_outstanding_p);
  localparam logic [C_PTR_W-1:0]  C_LAST   = C_PTR_W'(max_outstanding_p - 1);

  // Command output register
  logic                            r_cmd_v;
  logic [cce_mem_msg_width_lp-1:0] r_cmd;
  logic [cce_mem_msg_width_lp-1:0] w_cmd_next;

  // Credits double as the tracker occupancy: both move on accept/retire only
  logic [C_CNT_W-1:0]              r_credits;
  logic [C_PTR_W-1:0]              r_wr_ptr, r_rd_ptr;
  logic                            r_trk_we   [max_outstanding_p];
  logic [paddr_width_p-1:0]        r_trk_addr [max_outstanding_p];

  // Completion register and status
  logic                            r_rsp_v, r_rsp_we, r_mismatch;
  logic [dword_width_p-1:0]        r_rsp_data;

  logic                            w_blocked, w_accept, w_cmd_drain, w_trk_empty;
  logic                            w_retire, w_bad;
  logic                            w_head_we;
  logic [paddr_width_p-1:0]        w_head_addr;
  logic [C_TYPE_W-1:0]             w_resp_type, w_exp_type;
  logic [paddr_width_p-1:0]        w_resp_addr;
  logic [dword_width_p-1:0]        w_resp_data;
  logic                            w_unused_resp;

  assign w_trk_empty = (r_credits == '0);
  assign w_cmd_drain = r_cmd_v & mem_cmd_ready_i;

  // Outputs are forced low while reset is asserted
  assign req_ready_o     = ~reset_i & (~r_cmd_v | mem_cmd_ready_i)
                         & (r_credits < C_MAX) & ~w_blocked;
  assign w_accept        = req_v_i & req_ready_o;
  assign mem_resp_yumi_o = ~reset_i & mem_resp_v_i & (~r_rsp_v | rsp_yumi_i);

  assign w_resp_type = mem_resp_i[0 +: C_TYPE_W];
  assign w_resp_addr = mem_resp_i[C_ADDR_LSB +: paddr_width_p];
  assign w_resp_data = mem_resp_i[C_DATA_LSB +: dword_width_p];
  assign w_head_we   = r_trk_we[r_rd_ptr];
  assign w_head_addr = r_trk_addr[r_rd_ptr];
  assign w_exp_type  = w_head_we ? C_UC_WR : C_UC_RD;

  // A response with nothing outstanding is consumed but never delivered
  assign w_retire = mem_resp_yumi_o & ~w_trk_empty;
  assign w_bad    = mem_resp_yumi_o & (w_trk_empty | (w_resp_type != w_exp_type)
                                       | (w_resp_addr != w_head_addr));

  // Size/payload fields and upper block data of the response carry nothing we use
  assign w_unused_resp = ^{mem_resp_i[C_DATA_LSB-1:C_SIZE_LSB],
                           mem_resp_i[cce_mem_msg_width_lp-1:C_DATA_LSB+dword_width_p]};

  always_comb begin
    w_cmd_next = '0;
    w_cmd_next[0 +: C_TYPE_W]               = req_we_i ? C_UC_WR : C_UC_RD;
    w_cmd_next[C_ADDR_LSB +: paddr_width_p] = req_addr_i;
    w_cmd_next[C_SIZE_LSB +: C_SIZE_W]      = C_SIZE_8;
    if (req_we_i) begin
      w_cmd_next[C_DATA_LSB +: dword_width_p] = req_data_i;
    end
  end

  // Accept has priority: a new command may load while the old one drains
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cmd_v <= 1'b0;
      r_cmd   <= '0;
    end else if (w_accept) begin
      r_cmd_v <= 1'b1;
      r_cmd   <= w_cmd_next;
    end else if (w_cmd_drain) begin
      r_cmd_v <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_credits <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      if (w_accept && !w_retire) begin
        r_credits <= r_credits + C_CNT_W'(1);
      end else if (!w_accept && w_retire) begin
        r_credits <= r_credits - C_CNT_W'(1);
      end
      if (w_accept) begin
        r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + C_PTR_W'(1);
      end
      if (w_retire) begin
        r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + C_PTR_W'(1);
      end
    end
  end

  // Tracker storage needs no reset: occupancy is governed by r_credits
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_trk_we[r_wr_ptr]   <= req_we_i;
      r_trk_addr[r_wr_ptr] <= req_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rsp_v    <= 1'b0;
      r_rsp_we   <= 1'b0;
      r_rsp_data <= '0;
      r_mismatch <= 1'b0;
    end else begin
      if (w_retire) begin
        r_rsp_v    <= 1'b1;
        r_rsp_we   <= w_head_we;
        r_rsp_data <= w_head_we ? '0 : w_resp_data;
      end else if (rsp_yumi_i) begin
        r_rsp_v <= 1'b0;
      end
      if (w_bad) begin
        r_mismatch <= 1'b1;
      end
    end
  end

`ifdef BP_CLINT_INIT_TIMEOUT_EN
  localparam int C_TO_W = $clog2(timeout_cycles_p + 1);
  localparam logic [C_TO_W-1:0] C_TO_LIMIT = C_TO_W'(timeout_cycles_p);

  logic [C_TO_W-1:0] r_to_cnt;
  logic              r_timeout;
  logic              w_to_clear;

  // Only counts while something is outstanding and no response is retiring
  assign w_to_clear = mem_resp_yumi_o | w_trk_empty;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (w_to_clear) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != C_TO_LIMIT) begin
      r_to_cnt <= r_to_cnt + C_TO_W'(1);
      if (r_to_cnt == C_TO_LIMIT - C_TO_W'(1)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign w_blocked = r_timeout;
  assign timeout_o = r_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (timeout_cycles_p > 0);
  assign w_blocked    = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  assign mem_cmd_o   = r_cmd;
  assign mem_cmd_v_o = r_cmd_v;
  assign rsp_v_o     = r_rsp_v;
  assign rsp_we_o    = r_rsp_we;
  assign rsp_data_o  = r_rsp_data;
  assign mismatch_o  = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_bp_clint_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_clint_cmd_initiator
// Purpose  : Directed self-checking bench for bp_clint_cmd_initiator. The
//            bench plays both the requester and the CLINT responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_clint_cmd_initiator;

  localparam int PA    = 40;
  localparam int DW    = 64;
  localparam int BW    = 512;
  localparam int MSG_W = 4 + PA + 3 + 8 + BW;
  localparam int ADDR_LSB = 4;
  localparam int SIZE_LSB = 4 + PA;
  localparam int DATA_LSB = 4 + PA + 11;

  localparam logic [3:0]    UC_RD    = 4'b0010;
  localparam logic [3:0]    UC_WR    = 4'b0011;
  localparam logic [PA-1:0] MTIMECMP = 40'h00_0030_4000;

  logic             clk = 1'b0;
  logic             reset_i;
  logic             req_v_i, req_ready_o, req_we_i;
  logic [PA-1:0]    req_addr_i;
  logic [DW-1:0]    req_data_i;
  logic [MSG_W-1:0] mem_cmd_o, mem_resp_i;
  logic             mem_cmd_v_o, mem_cmd_ready_i, mem_resp_v_i, mem_resp_yumi_o;
  logic             rsp_v_o, rsp_we_o, rsp_yumi_i, mismatch_o, timeout_o;
  logic [DW-1:0]    rsp_data_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bp_clint_cmd_initiator #(
    .paddr_width_p    (PA),
    .dword_width_p    (DW),
    .cce_block_width_p(BW),
    .max_outstanding_p(2),
    .timeout_cycles_p (16)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .req_v_i        (req_v_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_data_i     (req_data_i),
    .mem_cmd_o      (mem_cmd_o),
    .mem_cmd_v_o    (mem_cmd_v_o),
    .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i     (mem_resp_i),
    .mem_resp_v_i   (mem_resp_v_i),
    .mem_resp_yumi_o(mem_resp_yumi_o),
    .rsp_v_o        (rsp_v_o),
    .rsp_we_o       (rsp_we_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_yumi_i     (rsp_yumi_i),
    .mismatch_o     (mismatch_o),
    .timeout_o      (timeout_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [MSG_W-1:0] mk_resp(input logic [3:0] t, input logic [PA-1:0] a,
                                               input logic [BW-1:0] d);
    logic [MSG_W-1:0] m;
    m = '0;
    m[3:0]             = t;
    m[ADDR_LSB +: PA]  = a;
    m[SIZE_LSB +: 3]   = 3'b011;
    m[DATA_LSB +: BW]  = d;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] d;
    int n;

    reset_i = 1'b1; req_v_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_data_i = '0;
    mem_cmd_ready_i = 1'b0; mem_resp_i = '0; mem_resp_v_i = 1'b0; rsp_yumi_i = 1'b0;
    tick();
    tick();
    check("rst_req_ready", 64'(req_ready_o), 0);
    check("rst_cmd_v",     64'(mem_cmd_v_o), 0);
    check("rst_cmd_low",   mem_cmd_o[63:0], 0);
    check("rst_rsp_v",     64'(rsp_v_o), 0);
    check("rst_rsp_data",  rsp_data_o, 0);
    check("rst_mismatch",  64'(mismatch_o), 0);
    check("rst_timeout",   64'(timeout_o), 0);
    reset_i = 1'b0;
    #1;
    check("post_rst_ready", 64'(req_ready_o), 1);

    // ---- write 0x1000 to mtimecmp, then read it back ----
    req_v_i = 1'b1; req_we_i = 1'b1; req_addr_i = MTIMECMP; req_data_i = 64'h1000;
    #1;
    check("wr_ready", 64'(req_ready_o), 1);
    tick();
    req_v_i = 1'b0;
    check("wr_cmd_v",    64'(mem_cmd_v_o), 1);
    check("wr_cmd_type", 64'(mem_cmd_o[3:0]), 64'(UC_WR));
    check("wr_cmd_addr", 64'(mem_cmd_o[ADDR_LSB +: PA]), 64'(MTIMECMP));
    check("wr_cmd_size", 64'(mem_cmd_o[SIZE_LSB +: 3]), 3);
    check("wr_cmd_data", mem_cmd_o[DATA_LSB +: 64], 64'h1000);
    check("wr_cmd_data_hi", mem_cmd_o[DATA_LSB+64 +: 64], 0);
    tick();
    check("wr_cmd_held", 64'(mem_cmd_v_o), 1);
    mem_cmd_ready_i = 1'b1;
    tick();
    check("wr_cmd_drained", 64'(mem_cmd_v_o), 0);
    mem_resp_i = mk_resp(UC_WR, MTIMECMP, '0); mem_resp_v_i = 1'b1;
    #1;
    check("wr_resp_yumi", 64'(mem_resp_yumi_o), 1);
    tick();
    mem_resp_v_i = 1'b0;
    check("wr_rsp_v",    64'(rsp_v_o), 1);
    check("wr_rsp_we",   64'(rsp_we_o), 1);
    check("wr_rsp_data", rsp_data_o, 0);
    rsp_yumi_i = 1'b1;
    tick();
    rsp_yumi_i = 1'b0;
    check("wr_rsp_drained", 64'(rsp_v_o), 0);

    req_v_i = 1'b1; req_we_i = 1'b0; req_addr_i = MTIMECMP; req_data_i = 64'hdead_beef;
    tick();
    req_v_i = 1'b0;
    check("rd_cmd_type", 64'(mem_cmd_o[3:0]), 64'(UC_RD));
    check("rd_cmd_addr", 64'(mem_cmd_o[ADDR_LSB +: PA]), 64'(MTIMECMP));
    check("rd_cmd_data", mem_cmd_o[DATA_LSB +: 64], 0);
    tick();
    check("rd_cmd_drained", 64'(mem_cmd_v_o), 0);
    d = '0; d[63:0] = 64'h1000; d[127:64] = 64'habcd_ef01_2345_6789;
    mem_resp_i = mk_resp(UC_RD, MTIMECMP, d); mem_resp_v_i = 1'b1;
    tick();
    mem_resp_v_i = 1'b0;
    check("rd_rsp_v",    64'(rsp_v_o), 1);
    check("rd_rsp_we",   64'(rsp_we_o), 0);
    check("rd_rsp_data", rsp_data_o, 64'h1000);
    check("rd_mismatch", 64'(mismatch_o), 0);
    rsp_yumi_i = 1'b1;
    tick();
    rsp_yumi_i = 1'b0;

    // ---- credit limit: third request waits for first retirement ----
    req_v_i = 1'b1; req_we_i = 1'b0; req_addr_i = 40'h100;
    tick();
    req_addr_i = 40'h108;
    #1;
    check("b_ready", 64'(req_ready_o), 1);
    tick();
    req_addr_i = 40'h110;
    #1;
    check("c_blocked", 64'(req_ready_o), 0);
    tick();
    check("c_blocked2", 64'(req_ready_o), 0);
    d = '0; d[63:0] = 64'h11;
    mem_resp_i = mk_resp(UC_RD, 40'h100, d); mem_resp_v_i = 1'b1;
    #1;
    check("a_yumi", 64'(mem_resp_yumi_o), 1);
    check("c_blocked_at_retire", 64'(req_ready_o), 0);
    tick();
    mem_resp_v_i = 1'b0;
    check("c_ready_after_retire", 64'(req_ready_o), 1);
    check("a_rsp_data", rsp_data_o, 64'h11);
    rsp_yumi_i = 1'b1;
    tick();
    req_v_i = 1'b0;
    check("full_after_c", 64'(req_ready_o), 0);

    // ---- accept and retire in the same cycle at one credit ----
    mem_resp_i = mk_resp(UC_RD, 40'h108, '0); mem_resp_v_i = 1'b1;
    tick();
    req_v_i = 1'b1; req_addr_i = 40'h118;
    mem_resp_i = mk_resp(UC_RD, 40'h110, '0);
    #1;
    check("d_ready", 64'(req_ready_o), 1);
    check("c_yumi",  64'(mem_resp_yumi_o), 1);
    tick();
    mem_resp_v_i = 1'b0;
    req_addr_i = 40'h120;
    #1;
    check("e_ready_credit1", 64'(req_ready_o), 1);
    check("d_cmd_addr", 64'(mem_cmd_o[ADDR_LSB +: PA]), 64'h118);
    tick();
    req_v_i = 1'b0;
    check("full_after_e", 64'(req_ready_o), 0);
    check("e_cmd_no_bubble", 64'(mem_cmd_v_o), 1);
    check("e_cmd_addr", 64'(mem_cmd_o[ADDR_LSB +: PA]), 64'h120);
    mem_resp_i = mk_resp(UC_RD, 40'h118, '0); mem_resp_v_i = 1'b1;
    tick();
    mem_resp_i = mk_resp(UC_RD, 40'h120, '0);
    tick();
    mem_resp_v_i = 1'b0;
    tick();
    rsp_yumi_i = 1'b0;
    check("seq_mismatch", 64'(mismatch_o), 0);
    check("seq_idle_ready", 64'(req_ready_o), 1);

    // ---- full completion buffer backpressures the responder ----
    req_v_i = 1'b1; req_addr_i = 40'h200;
    tick();
    req_addr_i = 40'h208;
    tick();
    req_v_i = 1'b0;
    d = '0; d[63:0] = 64'hf;
    mem_resp_i = mk_resp(UC_RD, 40'h200, d); mem_resp_v_i = 1'b1;
    tick();
    d = '0; d[63:0] = 64'h6;
    mem_resp_i = mk_resp(UC_RD, 40'h208, d);
    #1;
    check("g_stalled", 64'(mem_resp_yumi_o), 0);
    tick();
    check("g_stalled2", 64'(mem_resp_yumi_o), 0);
    check("f_held_data", rsp_data_o, 64'hf);
    rsp_yumi_i = 1'b1;
    #1;
    check("g_yumi_on_drain", 64'(mem_resp_yumi_o), 1);
    tick();
    rsp_yumi_i = 1'b0; mem_resp_v_i = 1'b0;
    check("g_rsp_v", 64'(rsp_v_o), 1);
    check("g_rsp_data", rsp_data_o, 64'h6);
    rsp_yumi_i = 1'b1;
    tick();
    rsp_yumi_i = 1'b0;
    check("g_drained", 64'(rsp_v_o), 0);

    // ---- address mismatch: sticky, response still delivered ----
    req_v_i = 1'b1; req_addr_i = 40'h20;
    tick();
    req_v_i = 1'b0;
    mem_resp_i = mk_resp(UC_RD, 40'h10, '0); mem_resp_v_i = 1'b1;
    tick();
    mem_resp_v_i = 1'b0;
    check("mm_set", 64'(mismatch_o), 1);
    check("mm_delivered", 64'(rsp_v_o), 1);
    rsp_yumi_i = 1'b1;
    repeat (3) tick();
    rsp_yumi_i = 1'b0;
    check("mm_sticky", 64'(mismatch_o), 1);
    check("mm_credit_back", 64'(req_ready_o), 1);
    do_reset();
    check("mm_cleared", 64'(mismatch_o), 0);

    // ---- response with nothing outstanding is dropped ----
    mem_resp_i = mk_resp(UC_RD, 40'h40, '0); mem_resp_v_i = 1'b1;
    #1;
    check("orphan_yumi", 64'(mem_resp_yumi_o), 1);
    tick();
    mem_resp_v_i = 1'b0;
    check("orphan_mismatch", 64'(mismatch_o), 1);
    check("orphan_dropped", 64'(rsp_v_o), 0);
    do_reset();

    // ---- watchdog: never respond ----
    req_v_i = 1'b1; req_addr_i = 40'h300;
    tick();
    req_v_i = 1'b0;
    n = 0;
`ifdef BP_CLINT_INIT_TIMEOUT_EN
    while (!timeout_o && n < 40) begin
      tick();
      n++;
    end
    check("to_set", 64'(timeout_o), 1);
    check("to_cycles", 64'(n), 16);
    check("to_blocks", 64'(req_ready_o), 0);
`else
    repeat (40) begin
      tick();
      n++;
    end
    check("to_absent", 64'(timeout_o), 0);
    check("to_no_block", 64'(req_ready_o), 1);
`endif
    do_reset();
    check("to_rst_timeout", 64'(timeout_o), 0);
    check("to_rst_ready", 64'(req_ready_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
